// File: rtl/scope_capture.sv
// Oscilloscope acquisition front end: decimates ADC samples, keeps a circular
// pre-trigger history, detects a level/edge trigger and streams one record out.
module scope_capture #(
  parameter int RECORD_LEN   = 640,
  parameter int PRETRIG      = 64,
  parameter int HOLDOFF      = 1024,
  parameter int AUTO_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic [3:0]  decim,
  input  logic [11:0] trig,
  input  logic        rising,
  input  logic        full,
  output logic [8:0]  sample,
  output logic        valid,
  output logic        sof,
  output logic        armed,
  output logic        forced,
  output logic [2:0]  dbg_state
);

  localparam int AW     = (RECORD_LEN > 1) ? $clog2(RECORD_LEN) : 1;
  localparam int CW     = $clog2(RECORD_LEN + 1);
  localparam int TW     = $clog2(AUTO_TIMEOUT + 2);
  localparam int HW     = $clog2(HOLDOFF + 2);
  localparam int POST_N = RECORD_LEN - PRETRIG - 1;
  localparam logic [AW-1:0] LAST_A = AW'(RECORD_LEN - 1);
  localparam logic [AW-1:0] PRE_A  = AW'(PRETRIG);
  localparam logic [AW-1:0] BACK_A = AW'(RECORD_LEN - PRETRIG);

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_DRAIN   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [3:0]    dcnt;
  logic          keep, capture, trig_hit, to_hit, fire, last_post;
  logic          adv, adv1, issue, xfer, last_xfer, hold_done;
  logic [AW-1:0] wptr, rptr, tptr, fill_cnt, post_cnt;
  logic [CW-1:0] out_cnt, iss_cnt;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] hold_cnt;
  logic [11:0]   prev;
  logic          prev_ok;
  logic [8:0]    ram [RECORD_LEN];
  logic [8:0]    rd_q;
  logic          rd_v, rd_sof;

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == LAST_A) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [AW-1:0] back_ptr(input logic [AW-1:0] p);
    return (p >= PRE_A) ? p - PRE_A : p + BACK_A;
  endfunction

  assign dbg_state = state_q;

  assign keep     = adc_valid && (dcnt == 4'd0);
  assign capture  = keep && (state_q == S_FILL || state_q == S_ARMED || state_q == S_POST);
  assign trig_hit = prev_ok && (rising ? (prev < trig && adc_data >= trig)
                                       : (prev > trig && adc_data <= trig));
  assign to_hit   = (AUTO_TIMEOUT != 0) && (int'(to_cnt) == AUTO_TIMEOUT - 1);
  assign fire     = capture && (state_q == S_ARMED) && (trig_hit || to_hit);
  assign last_post = capture && (state_q == S_POST) && (post_cnt == AW'(1));
  assign hold_done = int'(hold_cnt) >= HOLDOFF - 1;

  // Two-deep read pipeline (RAM read register, then output register). Each
  // stage advances only when the stage downstream of it can take a word, so
  // a stalled output holds while nothing is read past it.
  // Handshake: a word moves to the display on a cycle where valid && !full;
  // sample/sof stay stable while valid && full.
  assign adv       = !valid || !full;
  assign adv1      = !rd_v || adv;
  assign issue     = (state_q == S_DRAIN) && (iss_cnt != CW'(RECORD_LEN)) && adv1;
  assign xfer      = valid && !full;
  assign last_xfer = xfer && (out_cnt == CW'(RECORD_LEN - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:    if (capture && fill_cnt == AW'(PRETRIG - 1)) state_d = S_ARMED;
      S_ARMED:   if (fire) state_d = (POST_N == 0) ? S_DRAIN : S_POST;
      S_POST:    if (last_post) state_d = S_DRAIN;
      S_DRAIN:   if (last_xfer) state_d = S_HOLDOFF;
      S_HOLDOFF: if (hold_done) state_d = S_FILL;
      default:   state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FILL;
      dcnt     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      tptr     <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      out_cnt  <= '0;
      iss_cnt  <= '0;
      to_cnt   <= '0;
      hold_cnt <= '0;
      prev     <= '0;
      prev_ok  <= 1'b0;
      rd_v     <= 1'b0;
      rd_sof   <= 1'b0;
      sample   <= '0;
      valid    <= 1'b0;
      sof      <= 1'b0;
      armed    <= 1'b0;
      forced   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed   <= (state_d == S_ARMED);
      if (adc_valid) dcnt <= (dcnt >= decim) ? 4'd0 : dcnt + 4'd1;
      if (capture) begin
        wptr    <= inc_ptr(wptr);
        prev    <= adc_data;
        prev_ok <= 1'b1;
      end
      case (state_q)
        S_FILL: begin
          to_cnt <= '0;
          if (capture) fill_cnt <= fill_cnt + AW'(1);
        end
        S_ARMED: if (capture) begin
          if (fire) begin
            tptr     <= wptr;
            forced   <= !trig_hit;
            post_cnt <= AW'(POST_N);
            rptr     <= back_ptr(wptr);
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_POST: if (capture) begin
          post_cnt <= post_cnt - AW'(1);
          rptr     <= back_ptr(tptr);
        end
        S_HOLDOFF: hold_cnt <= hold_cnt + HW'(1);
        default: ;
      endcase
      // A fresh fill must not compare its first sample against stale history.
      if (state_d == S_FILL && state_q != S_FILL) begin
        fill_cnt <= '0;
        hold_cnt <= '0;
        prev_ok  <= 1'b0;
      end
      if (state_d == S_DRAIN && state_q != S_DRAIN) begin
        out_cnt <= '0;
        iss_cnt <= '0;
      end
      if (issue) begin
        rptr    <= inc_ptr(rptr);
        iss_cnt <= iss_cnt + CW'(1);
      end
      if (adv1) begin
        rd_v   <= issue;
        rd_sof <= issue && (iss_cnt == '0);
      end
      if (adv) begin
        sample <= rd_q;
        valid  <= rd_v;
        sof    <= rd_sof;
      end
      if (xfer) out_cnt <= out_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) ram[wptr] <= adc_data[11:3];
    if (issue) rd_q <= ram[rptr];
  end

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: rising/falling/decimated/backpressured
// records, auto and coincident triggers, holdoff re-arm and mid-drain reset.
module tb_scope_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [3:0]  decim;
  logic [11:0] trig;
  logic        rising;
  logic        full;

  logic [8:0] a_sample, b_sample;
  logic       a_valid, b_valid, a_sof, b_sof, a_armed, b_armed, a_forced, b_forced;
  logic [2:0] a_dbg, b_dbg;

  logic       sel;
  logic [8:0] m_sample;
  logic       m_valid, m_sof, m_armed, m_forced;
  logic [2:0] m_dbg;

  always #5 clk = ~clk;

  scope_capture dut_a (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .decim(decim), .trig(trig), .rising(rising), .full(full),
    .sample(a_sample), .valid(a_valid), .sof(a_sof), .armed(a_armed),
    .forced(a_forced), .dbg_state(a_dbg)
  );

  scope_capture #(.AUTO_TIMEOUT(1000)) dut_b (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .decim(decim), .trig(trig), .rising(rising), .full(full),
    .sample(b_sample), .valid(b_valid), .sof(b_sof), .armed(b_armed),
    .forced(b_forced), .dbg_state(b_dbg)
  );

  assign m_sample = sel ? b_sample : a_sample;
  assign m_valid  = sel ? b_valid  : a_valid;
  assign m_sof    = sel ? b_sof    : a_sof;
  assign m_armed  = sel ? b_armed  : a_armed;
  assign m_forced = sel ? b_forced : a_forced;
  assign m_dbg    = sel ? b_dbg    : a_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  int         xfer_cnt, armed_cnt, cyc_n, first_v, last_x;
  logic       mon_en = 1'b0;
  logic       hold_pend = 1'b0;
  logic [8:0] hold_s;
  logic       hold_sof;

  always @(negedge clk) begin
    cyc_n++;
    if (mon_en) begin
      if (m_armed) armed_cnt++;
      if (hold_pend) begin
        check("stall_valid", m_valid, 1);
        check("stall_sample", m_sample, hold_s);
        check("stall_sof", m_sof, hold_sof);
      end
      hold_pend = m_valid && full;
      hold_s    = m_sample;
      hold_sof  = m_sof;
      if (m_valid && first_v < 0) first_v = cyc_n;
      if (m_valid && !full) begin
        if (exp_q.size() == 0) begin
          check("extra_xfer", xfer_cnt, 640);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", m_sample, mon_e);
          check("sof", m_sof, (xfer_cnt == 0));
        end
        last_x = cyc_n;
        xfer_cnt++;
      end
    end
  end

  // driver
  int   n;
  int   mode;
  logic bp_on;

  function automatic logic [11:0] gen(input int v);
    case (mode)
      0:       return 12'(v);
      1:       return 12'(4095 - v);
      default: return 12'd100;
    endcase
  endfunction

  task automatic drive_inputs();
    adc_data = gen(n);
    full     = bp_on && (((n >= 2800) && (n < 2850)) || (n % 2 == 1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    drive_inputs();
  endtask

  task automatic start_record(input int md, input logic [3:0] dc, input logic [11:0] tl,
                              input logic rs, input logic s, input logic bp);
    mon_en    = 1'b0;
    reset     = 1'b1;
    mode      = md;
    decim     = dc;
    trig      = tl;
    rising    = rs;
    sel       = s;
    bp_on     = bp;
    adc_valid = 1'b1;
    n         = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sample", m_sample, 0);
    check("rst_valid", m_valid, 0);
    check("rst_sof", m_sof, 0);
    check("rst_armed", m_armed, 0);
    check("rst_forced", m_forced, 0);
    check("rst_state", m_dbg, 0);
    xfer_cnt  = 0;
    armed_cnt = 0;
    first_v   = -1;
    last_x    = -1;
    hold_pend = 1'b0;
    exp_q.delete();
    mon_en    = 1'b1;
    reset     = 1'b0;
  endtask

  task automatic run_record(input int stop_at, input int budget);
    int cyc = 0;
    while (xfer_cnt < stop_at && cyc < budget) begin
      step();
      cyc++;
    end
    if (xfer_cnt < stop_at) check("timeout_xfers", xfer_cnt, stop_at);
  endtask

  task automatic finish_record(input int exp_armed, input logic exp_forced, input logic chk_span);
    mon_en = 1'b0;
    check("armed_cycles", armed_cnt, exp_armed);
    check("forced", m_forced, exp_forced);
    check("exp_left", exp_q.size(), 0);
    if (chk_span) check("drain_span", last_x - first_v + 1, 640);
  endtask

  initial begin
    logic [11:0] c;
    int          wait_c;
    reset = 1'b1; adc_valid = 1'b0; adc_data = '0; decim = '0;
    trig = '0; rising = 1'b1; full = 1'b0; sel = 1'b0; bp_on = 1'b0; mode = 0; n = 0;

    // rising ramp, then holdoff re-arm timing
    start_record(0, 4'd0, 12'd2048, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 640; k++) exp_q.push_back(9'((1984 + k) >> 3));
    run_record(640, 6000);
    finish_record(1985, 1'b0, 1'b1);
    wait_c = 0;
    while (!m_armed && wait_c < 3000) begin
      step();
      wait_c++;
    end
    check("holdoff_rearm", wait_c, 1088);

    // falling ramp
    start_record(1, 4'd0, 12'd2048, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 640; k++) exp_q.push_back(9'((2112 - k) >> 3));
    run_record(640, 6000);
    finish_record(1984, 1'b0, 1'b1);

    // rising ramp under backpressure
    start_record(0, 4'd0, 12'd2048, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 640; k++) exp_q.push_back(9'((1984 + k) >> 3));
    run_record(640, 8000);
    finish_record(1985, 1'b0, 1'b0);

    // decimation by 4
    start_record(0, 4'd3, 12'd2048, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 640; k++) begin
      c = 12'(1792 + 4 * k);
      exp_q.push_back(c[11:3]);
    end
    run_record(640, 8000);
    finish_record(1796, 1'b0, 1'b1);

    // auto trigger on a flat input
    start_record(2, 4'd0, 12'd2048, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 640; k++) exp_q.push_back(9'd12);
    run_record(640, 4000);
    finish_record(1000, 1'b1, 1'b1);

    // real trigger on the same sample the timeout expires
    start_record(0, 4'd0, 12'd1063, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 640; k++) exp_q.push_back(9'((999 + k) >> 3));
    run_record(640, 4000);
    finish_record(1000, 1'b0, 1'b1);

    // reset while index 300 is offered, then a clean record
    start_record(0, 4'd0, 12'd2048, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 640; k++) exp_q.push_back(9'((1984 + k) >> 3));
    run_record(300, 6000);
    mon_en = 1'b0;
    check("pre_reset_valid", m_valid, 1);
    reset = 1'b1;
    #1;
    check("async_valid", m_valid, 0);
    check("async_sof", m_sof, 0);
    check("async_sample", m_sample, 0);
    start_record(0, 4'd0, 12'd2048, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 640; k++) exp_q.push_back(9'((1984 + k) >> 3));
    run_record(640, 6000);
    finish_record(1985, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
